// File: rtl/mul8_err_pkg.sv
// mul8_err_pkg: shared state encoding, product type and saturating accumulate helper
package mul8_err_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [15:0] prod_t;
  localparam int ACC_MAX_W = 64;
  // Bit ACC_MAX_W of the result flags that the w-bit sum clamped at all-ones
  function automatic logic [ACC_MAX_W:0] sat_add(
    input logic [ACC_MAX_W-1:0] acc,
    input logic [ACC_MAX_W-1:0] inc,
    input int unsigned w
  );
    logic [ACC_MAX_W:0] s;
    logic [ACC_MAX_W:0] lim;
    s = {1'b0, acc} + {1'b0, inc};
    lim = ((ACC_MAX_W+1)'(1) << w) - (ACC_MAX_W+1)'(1);
    return (s > lim) ? {1'b1, lim[ACC_MAX_W-1:0]} : {1'b0, s[ACC_MAX_W-1:0]};
  endfunction
endpackage

// File: rtl/mul8u_err_calc.sv
// mul8u_err_calc: two-stage exact product, absolute error and squared error pipeline
module mul8u_err_calc
  import mul8_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  prod_t       o,
  output logic        v1,
  output logic        v2,
  output prod_t       err,
  output logic [31:0] sq,
  output logic [7:0]  a_q,
  output logic [7:0]  b_q
);
  prod_t exact, o1, diff;
  logic [7:0] a1, b1;
  assign diff = exact >= o1 ? exact - o1 : o1 - exact;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= valid;
      v2 <= v1;
    end
    if (valid) begin
      exact <= 16'(a) * 16'(b);
      o1 <= o;
      a1 <= a;
      b1 <= b;
    end
    if (v1) begin
      err <= diff;
      sq <= 32'(diff) * 32'(diff);
      a_q <= a1;
      b_q <= b1;
    end
  end
endmodule

// File: rtl/mul8u_err_monitor.sv
// mul8u_err_monitor: run control, beat handshake and error statistics accumulation
module mul8u_err_monitor
  import mul8_err_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SUM_W = 48,
  parameter int SQ_W  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_o,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [CNT_W-1:0] res_err_cnt,
  output logic [SUM_W-1:0] res_sum_err,
  output logic [SQ_W-1:0]  res_sum_sq,
  output logic [15:0]      res_max_err,
  output logic [7:0]       res_max_a,
  output logic [7:0]       res_max_b,
  output logic             res_overflow
);
  state_t state;
  logic [CNT_W-1:0] target, accepted;
  logic accept, go, v1, v2;
  prod_t err;
  logic [31:0] sq;
  logic [7:0] ea, eb;
  logic [ACC_MAX_W:0] sum_nx, sq_nx;
  assign accept = in_valid & in_ready;
  assign go = state == IDLE && start;
  assign sum_nx = sat_add(ACC_MAX_W'(res_sum_err), ACC_MAX_W'(err), SUM_W);
  assign sq_nx = sat_add(ACC_MAX_W'(res_sum_sq), ACC_MAX_W'(sq), SQ_W);
  mul8u_err_calc calc (
    .clk(clk), .rst_n(rst_n), .valid(accept), .a(in_a), .b(in_b), .o(in_o),
    .v1(v1), .v2(v2), .err(err), .sq(sq), .a_q(ea), .b_q(eb)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      res_valid <= 1'b0;
      target <= '0;
      accepted <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          target <= n_samples;
          accepted <= '0;
          busy <= 1'b1;
          in_ready <= n_samples != '0;
          res_valid <= n_samples == '0;
          state <= n_samples == '0 ? DONE : RUN;
        end
        RUN: if (accept) begin
          accepted <= accepted + CNT_W'(1);
          if (accepted == target - CNT_W'(1)) begin
            in_ready <= 1'b0;
            state <= DRAIN;
          end
        end
        // Nothing enters stage 1 here, so once it empties the final beat accumulates on this edge
        DRAIN: if (!v1) begin
          res_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      res_count <= '0;
      res_err_cnt <= '0;
      res_sum_err <= '0;
      res_sum_sq <= '0;
      res_max_err <= '0;
      res_max_a <= '0;
      res_max_b <= '0;
      res_overflow <= 1'b0;
    end else if (v2) begin
      res_count <= res_count + CNT_W'(1);
      res_err_cnt <= res_err_cnt + CNT_W'(err != '0);
      res_sum_err <= sum_nx[SUM_W-1:0];
      res_sum_sq <= sq_nx[SQ_W-1:0];
      res_overflow <= res_overflow | sum_nx[ACC_MAX_W] | sq_nx[ACC_MAX_W];
      if (err > res_max_err) begin
        res_max_err <= err;
        res_max_a <= ea;
        res_max_b <= eb;
      end
    end
  end
endmodule

// File: tb/tb_mul8u_err_monitor.sv
// tb_mul8u_err_monitor: table, directed and randomized checks against an arithmetic reference model
module tb_mul8u_err_monitor;
  localparam int CNT_W = 32;
  typedef struct { logic [7:0] a, b; logic [15:0] o; } beat_t;
  typedef struct { longint count, err_cnt, sum_err, sum_sq, max_err, max_a, max_b; } res_t;
  typedef struct { int n; logic [0:3][7:0] a, b; logic [0:3][15:0] o; res_t exp; } vec_t;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, res_ready = 0;
  logic [CNT_W-1:0] n_samples = '0;
  logic [7:0] in_a = 0, in_b = 0;
  logic [15:0] in_o = 0;
  logic in_ready, busy, res_valid, res_overflow;
  logic [CNT_W-1:0] res_count, res_err_cnt;
  logic [47:0] res_sum_err;
  logic [63:0] res_sum_sq;
  logic [15:0] res_max_err;
  logic [7:0] res_max_a, res_max_b;
  logic s_in_ready, s_busy, s_res_valid, s_res_overflow;
  logic [CNT_W-1:0] s_res_count, s_res_err_cnt;
  logic [7:0] s_res_sum_err;
  logic [63:0] s_res_sum_sq;
  logic [15:0] s_res_max_err;
  logic [7:0] s_res_max_a, s_res_max_b;
  int checks = 0, errors = 0;
  vec_t tbl[3];
  always #5 clk = ~clk;
  mul8u_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_err_cnt(res_err_cnt), .res_sum_err(res_sum_err),
    .res_sum_sq(res_sum_sq), .res_max_err(res_max_err), .res_max_a(res_max_a),
    .res_max_b(res_max_b), .res_overflow(res_overflow)
  );
  mul8u_err_monitor #(.SUM_W(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(s_busy), .res_valid(s_res_valid), .res_ready(res_ready),
    .res_count(s_res_count), .res_err_cnt(s_res_err_cnt), .res_sum_err(s_res_sum_err),
    .res_sum_sq(s_res_sum_sq), .res_max_err(s_res_max_err), .res_max_a(s_res_max_a),
    .res_max_b(s_res_max_b), .res_overflow(s_res_overflow)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic res_t model(input beat_t q[$]);
    res_t r = '{default: 0};
    foreach (q[i]) begin
      int e;
      e = int'(q[i].a) * int'(q[i].b) - int'(q[i].o);
      if (e < 0) e = -e;
      r.count++;
      if (e != 0) r.err_cnt++;
      r.sum_err += e;
      r.sum_sq += longint'(e) * e;
      if (e > r.max_err) begin
        r.max_err = e;
        r.max_a = q[i].a;
        r.max_b = q[i].b;
      end
    end
    return r;
  endfunction
  task automatic check_res(input string tag, input res_t x);
    chk({tag, " count"}, res_count, x.count);
    chk({tag, " err_cnt"}, res_err_cnt, x.err_cnt);
    chk({tag, " sum_err"}, res_sum_err, x.sum_err);
    chk({tag, " sum_sq"}, res_sum_sq, x.sum_sq);
    chk({tag, " max_err"}, res_max_err, x.max_err);
    chk({tag, " max_a"}, res_max_a, x.max_a);
    chk({tag, " max_b"}, res_max_b, x.max_b);
    chk({tag, " overflow"}, res_overflow, 64'(x.sum_err > 64'hFFFF_FFFF_FFFF));
    chk({tag, " sat_count"}, s_res_count, x.count);
    chk({tag, " sat_sum_err"}, s_res_sum_err, x.sum_err > 255 ? 255 : x.sum_err);
    chk({tag, " sat_overflow"}, s_res_overflow, 64'(x.sum_err > 255));
  endtask
  task automatic start_run(input int n);
    start = 1;
    n_samples = CNT_W'(n);
    @(negedge clk);
    start = 0;
    n_samples = $urandom;
  endtask
  task automatic feed(input beat_t bt, input int gap);
    repeat (gap) @(negedge clk);
    in_a = bt.a;
    in_b = bt.b;
    in_o = bt.o;
    in_valid = 1;
    for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    in_a = $urandom;
    in_b = $urandom;
    in_o = $urandom;
  endtask
  task automatic run(input string tag, input beat_t q[$], input int gap, input int rrd, input res_t x);
    int t = 0;
    start_run(q.size());
    if (q.size() == 0) chk({tag, " done_next"}, res_valid, 1);
    foreach (q[i]) feed(q[i], gap);
    chk({tag, " in_ready_low"}, in_ready, 0);
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " res_valid"}, res_valid, 1);
    check_res(tag, x);
    for (int i = 0; i < rrd; i++) begin
      start = i == 0;
      n_samples = 7;
      @(negedge clk);
      start = 0;
      chk({tag, " hold_valid"}, res_valid, 1);
      chk({tag, " hold_busy"}, busy, 1);
      chk({tag, " hold_sum"}, res_sum_err, x.sum_err);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk({tag, " valid_drop"}, res_valid, 0);
    chk({tag, " idle"}, busy, 0);
    chk({tag, " readable"}, res_count, x.count);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    beat_t q[$];
    tbl[0] = '{n: 4, a: {8'd3, 8'd255, 8'd0, 8'd16}, b: {8'd5, 8'd255, 8'd9, 8'd16},
               o: {16'd15, 16'd65025, 16'd0, 16'd256}, exp: '{4, 0, 0, 0, 0, 0, 0}};
    tbl[1] = '{n: 3, a: {8'd255, 8'd10, 8'd255, 8'd0}, b: {8'd255, 8'd10, 8'd255, 8'd0},
               o: {16'd65010, 16'd97, 16'd65040, 16'd0}, exp: '{3, 3, 33, 459, 15, 255, 255}};
    tbl[2] = '{n: 0, a: '0, b: '0, o: '0, exp: '{0, 0, 0, 0, 0, 0, 0}};
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst count", res_count, 0);
    chk("rst sum_sq", res_sum_sq, 0);
    chk("rst overflow", res_overflow, 0);
    rst_n = 1;
    @(negedge clk);
    foreach (tbl[k]) begin
      q.delete();
      for (int i = 0; i < tbl[k].n; i++) q.push_back('{a: tbl[k].a[i], b: tbl[k].b[i], o: tbl[k].o[i]});
      run($sformatf("tbl%0d", k), q, 0, 0, tbl[k].exp);
    end
    q.delete();
    q.push_back('{a: 7, b: 9, o: 60});
    q.push_back('{a: 3, b: 7, o: 24});
    run("backpressure", q, 3, 5, '{2, 2, 6, 18, 3, 7, 9});
    q.delete();
    repeat (20) q.push_back('{a: 255, b: 255, o: 65010});
    run("saturate", q, 0, 1, model(q));
    q.delete();
    q.push_back('{a: 12, b: 12, o: 100});
    q.push_back('{a: 200, b: 2, o: 0});
    start_run(5);
    feed(q[0], 0);
    feed(q[1], 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst res_valid", res_valid, 0);
    chk("midrst count", res_count, 0);
    chk("midrst sum_err", res_sum_err, 0);
    chk("midrst max_err", res_max_err, 0);
    repeat (4) @(negedge clk);
    chk("midrst discard", res_count, 0);
    q.delete();
    q.push_back('{a: 100, b: 100, o: 9990});
    run("after_rst", q, 0, 0, '{1, 1, 10, 100, 10, 100, 100});
    for (int r = 0; r < 10; r++) begin
      int n = $urandom_range(1, 24);
      q.delete();
      for (int i = 0; i < n; i++) begin
        beat_t bt;
        int p, d, sel;
        bt.a = $urandom;
        bt.b = $urandom;
        p = int'(bt.a) * int'(bt.b);
        d = int'($urandom_range(0, 600)) - 300;
        sel = $urandom_range(0, 2);
        bt.o = sel == 0 ? 16'(p) : sel == 1 ? 16'(p + d < 0 ? 0 : p + d > 65535 ? 65535 : p + d) : 16'($urandom);
        q.push_back(bt);
      end
      run($sformatf("rand%0d", r), q, $urandom_range(0, 2), $urandom_range(0, 3), model(q));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
